// File: rtl/risc_pkg.sv
// Shared constants and types for the multicycle RISC datapath.
// Register file geometry, PC alias index and flag bit positions.
package risc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int PC_IDX = 7;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/flag_reg.sv
// Two-bit status register with an independent write enable per bit.
// Holds {carry, zero}; cleared by asynchronous reset.
module flag_reg
    import risc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] en_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [1:0] flag_q;
    logic [1:0] flag_d;

    always_comb begin
        flag_d = flag_q;
        for (int i = 0; i < 2; i++) begin
            if (en_i[i]) begin
                flag_d[i] = d_i[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign q_o = flag_q;

endmodule

// File: rtl/reg_file_pc.sv
// 8x16 general register file with R7 aliased as the program counter.
// Two combinational read ports, one general write port, one PC port.
module reg_file_pc #(
    parameter int DATA_W = risc_pkg::DATA_W,
    parameter int ADDR_W = risc_pkg::ADDR_W,
    parameter int PC_IDX = risc_pkg::PC_IDX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_wr,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_out,
    input  logic              c_wr,
    input  logic              z_wr,
    input  logic [1:0]        flags_in,
    output logic [1:0]        flags_out
);

    import risc_pkg::FLAG_C;
    import risc_pkg::FLAG_Z;

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = PC_IDX[ADDR_W-1:0];

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [1:0]        flag_en;

    // General write is applied last so it overrides the PC increment.
    always_comb begin
        regs_d = regs_q;
        if (pc_wr) begin
            regs_d[PC_A] = pc_in;
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];
    assign pc_out    = regs_q[PC_A];

    always_comb begin
        flag_en         = '0;
        flag_en[FLAG_C] = c_wr;
        flag_en[FLAG_Z] = z_wr;
    end

    flag_reg u_flags (
        .clk  (clk),
        .rst  (rst),
        .en_i (flag_en),
        .d_i  (flags_in),
        .q_o  (flags_out)
    );

endmodule

// File: tb/tb_reg_file_pc.sv
// Scoreboard bench for reg_file_pc: directed cases plus random traffic.
// Expected values come from a reference model of the register file.
module tb_reg_file_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] rd_data_a, rd_data_b, wr_data, pc_in, pc_out;
    logic        wr_en, pc_wr, c_wr, z_wr;
    logic [1:0]  flags_in, flags_out;

    always #5 clk = ~clk;

    reg_file_pc dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_wr     (pc_wr),
        .pc_in     (pc_in),
        .pc_out    (pc_out),
        .c_wr      (c_wr),
        .z_wr      (z_wr),
        .flags_in  (flags_in),
        .flags_out (flags_out)
    );

    typedef struct {
        int          sel;
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t         sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_regs [8];
    logic [1:0]  m_flags;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            0:       return rd_data_a;
            1:       return rd_data_b;
            2:       return pc_out;
            default: return {14'd0, flags_out};
        endcase
    endfunction

    task automatic push(input int sel, input string tag,
                        input logic [15:0] exp);
        sb_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic push_model(input string tag);
        push(0, {tag, "_a"}, m_regs[rd_addr_a]);
        push(1, {tag, "_b"}, m_regs[rd_addr_b]);
        push(2, {tag, "_pc"}, m_regs[7]);
        push(3, {tag, "_fl"}, {14'd0, m_flags});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_flags = 2'b00;
    endtask

    // Advance one edge, update the model with the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (pc_wr) m_regs[7] = pc_in;
            if (wr_en) m_regs[wr_addr] = wr_data;
            if (c_wr)  m_flags[1] = flags_in[1];
            if (z_wr)  m_flags[0] = flags_in[0];
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 0; pc_wr = 0; c_wr = 0; z_wr = 0;
    endtask

    initial begin
        rst = 1; idle();
        rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0;
        wr_data = 0; pc_in = 0; flags_in = 0;
        model_reset();
        tick(); tick();
        push(2, "rst_pc", 16'h0);
        push(3, "rst_fl", 16'h0);
        push(0, "rst_a", 16'h0);
        drain();
        @(negedge clk); rst = 0;

        // Write/read with no bypass
        wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
        rd_addr_a = 5; rd_addr_b = 5;
        #1;
        push(0, "wr_same_cyc", 16'h0);
        drain();
        tick(); idle();
        push(0, "wr_next_a", 16'h1234);
        push(1, "wr_next_b", 16'h1234);
        push_model("wr");
        drain();

        // Asynchronous reset clears state before the next edge
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
        c_wr = 1; z_wr = 1; flags_in = 2'b11;
        tick(); idle();
        rd_addr_a = 3; rd_addr_b = 7;
        #1;
        push(0, "pre_rst_r3", 16'hBEEF);
        push(3, "pre_rst_fl", 16'h3);
        drain();
        @(negedge clk); rst = 1; model_reset();
        #1;
        push(0, "arst_a", 16'h0);
        push(1, "arst_b", 16'h0);
        push(2, "arst_pc", 16'h0);
        push(3, "arst_fl", 16'h0);
        drain();
        wr_en = 1; wr_addr = 1; wr_data = 16'hFFFF;
        tick();
        @(negedge clk); rst = 0; idle();
        rd_addr_a = 1;
        #1;
        push(0, "rst_wr_ignored", 16'h0);
        drain();

        // PC increment, port A tracks the PC
        rd_addr_a = 7;
        for (int i = 1; i <= 4; i++) begin
            pc_wr = 1; pc_in = m_regs[7] + 16'd1;
            tick();
            push(2, $sformatf("pc_inc%0d", i), 16'(i));
            push(0, $sformatf("pc_rda%0d", i), 16'(i));
            drain();
        end
        idle();

        // Collision: general write to R7 overrides PC port
        wr_en = 1; wr_addr = 7; wr_data = 16'h0040;
        pc_wr = 1; pc_in = 16'h0005;
        tick();
        push(2, "coll_pc", 16'h0040);
        drain();
        wr_addr = 2; rd_addr_a = 2;
        tick(); idle();
        push(0, "dual_r2", 16'h0040);
        push(2, "dual_pc", 16'h0005);
        drain();

        // Flags with independent enables
        c_wr = 1; z_wr = 0; flags_in = 2'b11;
        tick();
        push(3, "fl_c_only", 16'h2);
        drain();
        c_wr = 0; z_wr = 1; flags_in = 2'b01;
        tick();
        push(3, "fl_z_only", 16'h3);
        drain();
        c_wr = 1; z_wr = 1; flags_in = 2'b00;
        tick(); idle();
        push(3, "fl_both", 16'h0);
        drain();

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            pc_wr     = 1'($urandom_range(0, 1));
            pc_in     = 16'($urandom);
            c_wr      = 1'($urandom_range(0, 1));
            z_wr      = 1'($urandom_range(0, 1));
            flags_in  = 2'($urandom_range(0, 3));
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = 3'($urandom_range(0, 7));
            #1;
            push_model("rnd_pre");
            drain();
            tick();
            push_model("rnd");
            drain();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_pc.md
Name: reg_file_pc

Overview:
- 8-entry x 16-bit general register file for the multicycle RISC datapath.
- Sits directly upstream of the A/B operand holding registers; its read ports feed their inputs. Downstream of the ALU-out/memory-data write-back path.
- R7 doubles as the program counter, with a dedicated PC port.
- Also holds the 2-bit carry/zero flag register with independent per-flag write enables.

Parameters:
- DATA_W, 16, register and PC width.
- ADDR_W, 3, register address width (2**ADDR_W entries).
- PC_IDX, 7, index of the register aliased as the PC.

Ports:
- clk  in  1  system clock; all updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- wr_en  in  1  general write enable.
- wr_addr  in  ADDR_W  general write address.
- wr_data  in  DATA_W  general write data.
- pc_wr  in  1  PC write enable (dedicated port).
- pc_in  in  DATA_W  next PC value.
- pc_out  out  DATA_W  current contents of R[PC_IDX].
- c_wr  in  1  carry flag write enable.
- z_wr  in  1  zero flag write enable.
- flags_in  in  2  {carry, zero} next values.
- flags_out  out  2  {carry, zero} current values.

Behaviour:
- Reset: rst high, asynchronously, clears R0..R7 and flags_out to 0. pc_out, rd_data_a, rd_data_b and flags_out therefore all read 0 during reset. All writes are ignored while rst is high.
- Reads are combinational: rd_data_x = R[rd_addr_x], with zero cycles of latency.
- No write-through bypass. A read of an address being written in the same cycle returns the old value; the new value is visible after the edge.
- Both read ports may address the same register at once; both return the same value.
- General write: on a clock edge with wr_en=1, R[wr_addr] <= wr_data.
- PC write: on a clock edge with pc_wr=1, R[PC_IDX] <= pc_in.
- Write collision: if wr_en=1, wr_addr=PC_IDX and pc_wr=1 in the same cycle, the general write wins and R7 <= wr_data. This applies to jump/branch write-back over the PC increment.
- pc_wr with wr_en to another address: both writes take effect in the same edge.
- Flags: carry <= flags_in[1] when c_wr=1; zero <= flags_in[0] when z_wr=1. Each flag is held independently otherwise.
- Flag writes are independent of register writes.
- No arithmetic inside the block; values are stored bit-exact, and no wrap or width conversion is applied.
- If rst is asserted mid-instruction, state clears immediately. The first edge after rst falls accepts writes normally.
- No X propagation from unused enables: all enables are sampled as-is, with no latching of addresses.

Decomposition:
- Shared package risc_pkg:
  - DATA_W, ADDR_W, PC_IDX constants.
  - Flag bit index constants: FLAG_C=1, FLAG_Z=0.
  - reg_addr_t typedef.
- One natural sub-module, flag_reg: 2-bit register with per-bit enables and async reset. It is instantiated once for {C, Z}.
- The register array and PC aliasing stay in reg_file_pc.

Test Plan:
- Reset: load R3=16'hBEEF, set flags=2'b11, pulse rst between clock edges -> all read ports, pc_out and flags_out are 0 immediately, before the next edge.
- Write/read: wr_en=1, wr_addr=5, wr_data=16'h1234 -> same-cycle rd_data_a(addr 5)=old value 0; next cycle rd_data_a=rd_data_b=16'h1234.
- PC increment: pc_wr=1, pc_in=pc_out+1 for 4 cycles from reset -> pc_out 1,2,3,4; rd_addr_a=7 tracks pc_out.
- Collision: wr_en=1, wr_addr=7, wr_data=16'h0040, pc_wr=1, pc_in=16'h0005 -> pc_out=16'h0040. Repeat with wr_addr=2 -> R2=16'h0040 and pc_out=16'h0005.
- Flags: flags_in=2'b11 with c_wr=1, z_wr=0 -> flags_out=2'b10; then flags_in=2'b01 with z_wr=1 only -> flags_out=2'b11; then both enables with 2'b00 -> 2'b00.
- Write with rst high: wr_en=1, wr_addr=1, data 16'hFFFF during rst -> R1 stays 0 after rst falls.
